// File: rtl/usb_rx_packet.sv
// USB low/full-speed packet receiver: NRZI decode, SYNC hunt, bit unstuffing,
// PID check, payload capture with CRC16 check and EOP validation.
// Optional feature macro: USB_RX_ERRCNT_EN adds a saturating err_count[7:0] output.
module usb_rx_packet #(
    parameter int unsigned DATA_BYTES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned STUFF_LEN      = 6
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    dp,
    input  logic                    dm,
    input  logic                    start_data,
    input  logic                    start_hs,
    output logic                    busy,
    output logic                    done,
    output logic                    success,
    output logic [2:0]              err_code,
    output logic [3:0]              pid,
    output logic                    ack,
    output logic                    nak,
    output logic [8*DATA_BYTES-1:0] rx_data
`ifdef USB_RX_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int unsigned DBITS = 8 * DATA_BYTES;
    localparam int unsigned BCW   = (DBITS > 16) ? $clog2(DBITS) : 5;
    localparam int unsigned TCW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned OCW   = $clog2(STUFF_LEN + 1);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_PID     = 3'd2;
    localparam logic [2:0] ERR_STUFF   = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_EOP     = 3'd5;
    localparam logic [2:0] ERR_UNEXP   = 3'd6;

    localparam logic [3:0]  PID_DATA0  = 4'b0011;
    localparam logic [3:0]  PID_DATA1  = 4'b1011;
    localparam logic [3:0]  PID_ACK    = 4'b0010;
    localparam logic [3:0]  PID_NAK    = 4'b1010;
    localparam logic [15:0] CRC_POLY   = 16'h8005;
    localparam logic [15:0] CRC_RESID  = 16'h800D;
    localparam logic [7:0]  SYNC_PAT   = 8'b0000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC,
        S_EOP
    } state_t;

    state_t             state_q, state_d;
    logic               prev_dp_q;
    logic               mode_data_q;
    logic [7:0]         sync_sr_q;
    logic [TCW-1:0]     tcnt_q;
    logic [OCW-1:0]     ones_q;
    logic [BCW-1:0]     bcnt_q;
    logic [7:0]         pid_sr_q;
    logic [DBITS-1:0]   shadow_q;
    logic [15:0]        crc_q;

    logic               bit_c;
    logic               se0_c;
    logic               j_c;
    logic               zone_c;
    logic               stuff_slot_c;
    logic               take_c;
    logic [7:0]         sync_win_c;
    logic [7:0]         pid_byte_c;
    logic               crc_fb_c;
    logic [15:0]        crc_next_c;
    logic               fin_c;
    logic               fin_ok_c;
    logic [2:0]         fin_err_c;

    // Line decode, unstuff slot detection and CRC next-state
    assign bit_c        = (dp == prev_dp_q);
    assign se0_c        = ~dp & ~dm;
    assign j_c          = dp & ~dm;
    assign zone_c       = (state_q == S_PID) || (state_q == S_DATA) || (state_q == S_CRC);
    assign stuff_slot_c = zone_c && (ones_q == OCW'(STUFF_LEN));
    assign take_c       = zone_c && !se0_c && !stuff_slot_c;
    assign sync_win_c   = {sync_sr_q[6:0], bit_c};
    assign pid_byte_c   = {bit_c, pid_sr_q[7:1]};
    assign crc_fb_c     = bit_c ^ crc_q[15];
    assign crc_next_c   = {crc_q[14:0], 1'b0} ^ (crc_fb_c ? CRC_POLY : 16'h0000);

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and attempt completion decode
    always_comb begin
        state_d   = state_q;
        fin_c     = 1'b0;
        fin_ok_c  = 1'b0;
        fin_err_c = ERR_OK;
        case (state_q)
            S_IDLE: begin
                if (start_data || start_hs) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (sync_win_c == SYNC_PAT) begin
                    state_d = S_PID;
                end else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_TIMEOUT;
                end
            end
            S_PID, S_DATA, S_CRC: begin
                if (se0_c) begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_EOP;
                end else if (stuff_slot_c) begin
                    if (bit_c) begin
                        fin_c     = 1'b1;
                        fin_err_c = ERR_STUFF;
                    end
                end else if (state_q == S_PID) begin
                    if (bcnt_q == BCW'(7)) begin
                        if (pid_byte_c[7:4] != ~pid_byte_c[3:0]) begin
                            fin_c     = 1'b1;
                            fin_err_c = ERR_PID;
                        end else if (mode_data_q) begin
                            if (pid_byte_c[3:0] == PID_DATA0 || pid_byte_c[3:0] == PID_DATA1) begin
                                state_d = S_DATA;
                            end else begin
                                fin_c     = 1'b1;
                                fin_err_c = ERR_UNEXP;
                            end
                        end else if (pid_byte_c[3:0] == PID_ACK || pid_byte_c[3:0] == PID_NAK) begin
                            state_d = S_EOP;
                        end else begin
                            fin_c     = 1'b1;
                            fin_err_c = ERR_UNEXP;
                        end
                    end
                end else if (state_q == S_DATA) begin
                    if (bcnt_q == BCW'(DBITS - 1)) begin
                        state_d = S_CRC;
                    end
                end else begin
                    if (bcnt_q == BCW'(15)) begin
                        if (crc_next_c != CRC_RESID) begin
                            fin_c     = 1'b1;
                            fin_err_c = ERR_CRC;
                        end else begin
                            state_d = S_EOP;
                        end
                    end
                end
            end
            S_EOP: begin
                if (bcnt_q == BCW'(0) || bcnt_q == BCW'(1)) begin
                    if (!se0_c) begin
                        fin_c     = 1'b1;
                        fin_err_c = ERR_EOP;
                    end
                end else if (j_c) begin
                    fin_c    = 1'b1;
                    fin_ok_c = 1'b1;
                end else begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_EOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (fin_c) begin
            state_d = S_IDLE;
        end
    end

    // Receive datapath: NRZI history, shift registers, counters and CRC
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            prev_dp_q   <= 1'b1;
            mode_data_q <= 1'b0;
            sync_sr_q   <= 8'hFF;
            tcnt_q      <= '0;
            ones_q      <= '0;
            bcnt_q      <= '0;
            pid_sr_q    <= '0;
            shadow_q    <= '0;
            crc_q       <= 16'hFFFF;
        end else begin
            prev_dp_q <= (state_q == S_IDLE) ? 1'b1 : dp;

            if (state_q == S_IDLE && (start_data || start_hs)) begin
                mode_data_q <= start_data;
            end

            sync_sr_q <= (state_q == S_SYNC) ? sync_win_c : 8'hFF;
            tcnt_q    <= (state_q == S_SYNC) ? tcnt_q + TCW'(1) : '0;

            if (!zone_c || stuff_slot_c) begin
                ones_q <= '0;
            end else if (take_c) begin
                ones_q <= bit_c ? ones_q + OCW'(1) : '0;
            end

            if (state_d != state_q) begin
                bcnt_q <= '0;
            end else if (take_c || state_q == S_EOP) begin
                bcnt_q <= bcnt_q + BCW'(1);
            end

            if (take_c && state_q == S_PID) begin
                pid_sr_q <= pid_byte_c;
            end

            if (take_c && state_q == S_DATA) begin
                shadow_q <= {bit_c, shadow_q[DBITS-1:1]};
            end

            if (take_c && (state_q == S_DATA || state_q == S_CRC)) begin
                crc_q <= crc_next_c;
            end else if (state_q == S_IDLE || state_q == S_SYNC || state_q == S_PID) begin
                crc_q <= 16'hFFFF;
            end
        end
    end

    // Registered status pulses and last-good packet capture
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            success  <= 1'b0;
            err_code <= ERR_OK;
            ack      <= 1'b0;
            nak      <= 1'b0;
            pid      <= '0;
            rx_data  <= '0;
        end else begin
            busy     <= (state_d != S_IDLE);
            done     <= fin_c;
            success  <= fin_ok_c;
            err_code <= fin_err_c;
            ack      <= fin_ok_c && !mode_data_q && (pid_sr_q[3:0] == PID_ACK);
            nak      <= fin_ok_c && !mode_data_q && (pid_sr_q[3:0] == PID_NAK);
            if (fin_ok_c) begin
                pid <= pid_sr_q[3:0];
                if (mode_data_q) begin
                    rx_data <= shadow_q;
                end
            end
        end
    end

`ifdef USB_RX_ERRCNT_EN
    // Saturating count of failed attempts
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_count <= 8'h00;
        end else if (fin_c && !fin_ok_c && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed bench for usb_rx_packet: bus-level NRZI/stuffing encoder plus an
// expected-result queue popped whenever the receiver reports done.
module tb_usb_rx_packet;

    localparam int unsigned DB    = 8;
    localparam int unsigned RXW   = 8 * DB;
    localparam int          STUFF = 6;

    logic           clk;
    logic           rst_l;
    logic           dp;
    logic           dm;
    logic           start_data;
    logic           start_hs;
    logic           busy;
    logic           done;
    logic           success;
    logic [2:0]     err_code;
    logic [3:0]     pid;
    logic           ack;
    logic           nak;
    logic [RXW-1:0] rx_data;
`ifdef USB_RX_ERRCNT_EN
    logic [7:0]     err_count;
`endif

    usb_rx_packet #(
        .DATA_BYTES     (DB),
        .TIMEOUT_CYCLES (255),
        .STUFF_LEN      (STUFF)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .dp         (dp),
        .dm         (dm),
        .start_data (start_data),
        .start_hs   (start_hs),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .err_code   (err_code),
        .pid        (pid),
        .ack        (ack),
        .nak        (nak),
        .rx_data    (rx_data)
`ifdef USB_RX_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic           ok;
        logic [2:0]     err;
        logic           ack;
        logic           nak;
        logic [3:0]     pid;
        logic [RXW-1:0] rx;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             n_vec   = 0;
    int             n_err   = 0;
    int             cyc     = 0;
    int             arm_cyc = 0;
    int             tx_ones = 0;
    int             m_errs  = 0;
    logic           lvl     = 1'b1;
    logic [7:0]     pl [DB];
    logic [3:0]     m_pid   = 4'h0;
    logic [RXW-1:0] m_rx    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RXW-1:0] obs, input logic [RXW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare one expected result whenever done is seen
    task automatic poll();
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", RXW'(done), RXW'(0));
            end else begin
                e = sb.pop_front();
                if (!e.ok && m_errs < 255) m_errs++;
                chk("success",      RXW'(success),  RXW'(e.ok));
                chk("err_code",     RXW'(err_code), RXW'(e.err));
                chk("ack",          RXW'(ack),      RXW'(e.ack));
                chk("nak",          RXW'(nak),      RXW'(e.nak));
                chk("pid",          RXW'(pid),      RXW'(e.pid));
                chk("rx_data",      rx_data,        e.rx);
                chk("busy_at_done", RXW'(busy),     RXW'(0));
                if (e.lat >= 0) chk("latency", RXW'(cyc - arm_cyc), RXW'(e.lat));
`ifdef USB_RX_ERRCNT_EN
                chk("err_count", RXW'(err_count), RXW'(m_errs));
`endif
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        poll();
    endtask

    task automatic line(input logic p, input logic m);
        tick();
        dp = p;
        dm = m;
    endtask

    task automatic raw(input logic b);
        if (!b) lvl = ~lvl;
        line(lvl, ~lvl);
    endtask

    task automatic tx_bit(input logic b, input logic stuff_en);
        if (stuff_en && tx_ones == STUFF) begin
            raw(1'b0);
            tx_ones = 0;
        end
        raw(b);
        tx_ones = b ? tx_ones + 1 : 0;
    endtask

    task automatic tx_byte(input logic [7:0] v, input logic stuff_en);
        for (int i = 0; i < 8; i++) tx_bit(v[i], stuff_en);
    endtask

    task automatic arm(input logic sd, input logic sh);
        tick();
        start_data = sd;
        start_hs   = sh;
        lvl        = 1'b1;
        tick();
        start_data = 1'b0;
        start_hs   = 1'b0;
        arm_cyc    = cyc;
    endtask

    task automatic sync();
        for (int i = 0; i < 7; i++) raw(1'b0);
        raw(1'b1);
        tx_ones = 0;
    endtask

    task automatic eop();
        line(1'b0, 1'b0);
        line(1'b0, 1'b0);
        line(1'b1, 1'b0);
        lvl = 1'b1;
    endtask

    // CRC-16/USB in reflected byte form; returns the complemented remainder
    function automatic logic [15:0] crc16();
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < DB; i++) begin
            r = r ^ {8'h00, pl[i]};
            for (int j = 0; j < 8; j++) begin
                if (r[0]) r = (r >> 1) ^ 16'hA001;
                else      r = r >> 1;
            end
        end
        return ~r;
    endfunction

    function automatic logic [RXW-1:0] pack();
        logic [RXW-1:0] r;
        r = '0;
        for (int i = 0; i < DB; i++) r[8*i +: 8] = pl[i];
        return r;
    endfunction

    task automatic data_pkt(input logic [7:0] pidb, input logic se, input int flip, input logic both);
        logic [15:0] c;
        logic [7:0]  b;
        c = crc16();
        arm(1'b1, both);
        sync();
        tx_byte(pidb, se);
        for (int i = 0; i < DB; i++) begin
            b = pl[i];
            if (flip >= 0 && flip / 8 == i) b[flip % 8] = ~b[flip % 8];
            tx_byte(b, se);
        end
        tx_byte(c[7:0], se);
        tx_byte(c[15:8], se);
        eop();
    endtask

    task automatic hs_pkt(input logic [7:0] pidb);
        arm(1'b0, 1'b1);
        sync();
        tx_byte(pidb, 1'b1);
        eop();
    endtask

    task automatic exp_ok(input logic [3:0] p, input logic [RXW-1:0] r, input logic a, input logic n);
        exp_t e;
        m_pid = p;
        m_rx  = r;
        e.ok = 1'b1; e.err = 3'd0; e.ack = a; e.nak = n;
        e.pid = p; e.rx = r; e.lat = -1;
        sb.push_back(e);
    endtask

    task automatic exp_fail(input logic [2:0] c, input int lat);
        exp_t e;
        e.ok = 1'b0; e.err = c; e.ack = 1'b0; e.nak = 1'b0;
        e.pid = m_pid; e.rx = m_rx; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain", RXW'(sb.size()), RXW'(0));
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_l = 1'b0; dp = 1'b1; dm = 1'b0; start_data = 1'b0; start_hs = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    RXW'(busy),     RXW'(0));
        chk("rst_done",    RXW'(done),     RXW'(0));
        chk("rst_success", RXW'(success),  RXW'(0));
        chk("rst_err",     RXW'(err_code), RXW'(0));
        chk("rst_pid",     RXW'(pid),      RXW'(0));
        chk("rst_ack_nak", RXW'({ack, nak}), RXW'(0));
        chk("rst_rx",      rx_data,        RXW'(0));
        rst_l = 1'b1;
        tick();

        // Good DATA0 packet with payload 01..08
        for (int i = 0; i < DB; i++) pl[i] = 8'(i + 1);
        exp_ok(4'h3, 64'h0807060504030201, 1'b0, 1'b0);
        data_pkt(8'hC3, 1'b1, -1, 1'b0);
        drain(40);

        // Handshakes ACK then NAK
        exp_ok(4'h2, m_rx, 1'b1, 1'b0);
        hs_pkt(8'hD2);
        drain(40);
        exp_ok(4'hA, m_rx, 1'b0, 1'b1);
        hs_pkt(8'h5A);
        drain(40);

        // SYNC hunt timeout with idle J
        exp_fail(3'd1, 255);
        arm(1'b1, 1'b0);
        drain(400);

        // Seven ones without a stuffed bit
        for (int i = 0; i < DB; i++) pl[i] = 8'h00;
        pl[0] = 8'hFF; pl[1] = 8'hFF;
        exp_fail(3'd3, -1);
        data_pkt(8'hC3, 1'b0, -1, 1'b0);
        drain(40);

        // Correctly stuffed 0xFF bytes, DATA1
        exp_ok(4'hB, pack(), 1'b0, 1'b0);
        data_pkt(8'h4B, 1'b1, -1, 1'b0);
        drain(40);

        // Single flipped payload bit
        for (int i = 0; i < DB; i++) pl[i] = 8'(i + 1);
        exp_fail(3'd4, -1);
        data_pkt(8'hC3, 1'b1, 13, 1'b0);
        drain(40);

        // PID check-nibble failure
        exp_fail(3'd2, -1);
        arm(1'b1, 1'b0); sync(); tx_byte(8'hC2, 1'b1); eop();
        drain(40);

        // ACK while expecting data
        exp_fail(3'd6, -1);
        arm(1'b1, 1'b0); sync(); tx_byte(8'hD2, 1'b1); eop();
        drain(40);

        // DATA0 while expecting handshake
        exp_fail(3'd6, -1);
        hs_pkt(8'hC3);
        drain(40);

        // Both starts high selects DATA mode; random payload
        for (int i = 0; i < DB; i++) pl[i] = 8'($urandom);
        exp_ok(4'h3, pack(), 1'b0, 1'b0);
        data_pkt(8'hC3, 1'b1, -1, 1'b1);
        drain(40);

        // SE0 in the middle of the payload
        exp_fail(3'd5, -1);
        arm(1'b1, 1'b0); sync(); tx_byte(8'hC3, 1'b1); tx_byte(8'h55, 1'b1);
        line(1'b0, 1'b0);
        eop();
        drain(40);

        // Truncated EOP (SE0 then J)
        exp_fail(3'd5, -1);
        arm(1'b0, 1'b1); sync(); tx_byte(8'hD2, 1'b1);
        line(1'b0, 1'b0);
        line(1'b1, 1'b0);
        lvl = 1'b1;
        drain(40);

        // Reset in the middle of a payload
        arm(1'b1, 1'b0); sync(); tx_byte(8'hC3, 1'b1); tx_byte(8'h12, 1'b1); tx_byte(8'h34, 1'b1);
        tick();
        rst_l = 1'b0;
        #1;
        chk("midrst_busy", RXW'(busy),     RXW'(0));
        chk("midrst_done", RXW'(done),     RXW'(0));
        chk("midrst_err",  RXW'(err_code), RXW'(0));
        chk("midrst_pid",  RXW'(pid),      RXW'(0));
        chk("midrst_rx",   rx_data,        RXW'(0));
        m_pid  = 4'h0;
        m_rx   = '0;
        m_errs = 0;
`ifdef USB_RX_ERRCNT_EN
        chk("midrst_errcnt", RXW'(err_count), RXW'(0));
`endif
        tick();
        dp = 1'b1; dm = 1'b0; lvl = 1'b1;
        tick();
        rst_l = 1'b1;
        tick();

        // Good packet after reset
        for (int i = 0; i < DB; i++) pl[i] = 8'(8'hA0 + i);
        exp_ok(4'h3, pack(), 1'b0, 1'b0);
        data_pkt(8'hC3, 1'b1, -1, 1'b0);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
